mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 120 ++++++++++++
 tb/tb_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester round-robin front end for a 6x6 unsigned
// multiplier with a registered, backpressured result port.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req0_valid/ready, req0_f/g  requester 0 handshake and operands
//   req1_valid/ready, req1_f/g  requester 1 handshake and operands
//   res_valid/ready             result handshake
//   res_data, res_id            12-bit product and owning requester index
//   busy                        high whenever the FSM is not IDLE
//   done_cnt                    saturating count of result handshakes
//
// state | meaning
// IDLE  | waiting for a request; ready driven to the granted requester
// CALC  | operands latched, product settling for CALC_CYCLES edges
// HOLD  | result registered, waiting for res_ready
module mul_arbiter #(
  parameter int CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [5:0]  req0_f,
  input  logic [5:0]  req0_g,
  input  logic [5:0]  req1_f,
  input  logic [5:0]  req1_g,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_data,
  output logic        res_id,
  output logic        busy,
  output logic [7:0]  done_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  logic [1:0]  state;
  logic        ptr;
  logic [3:0]  cnt;
  logic [5:0]  f_q;
  logic [5:0]  g_q;
  logic        id_q;
  logic [11:0] prod;
  logic        grant_id;
  logic        accept;

  // With a single valid the grant goes to it; the pointer only breaks ties.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ptr;
    else                          grant_id = req1_valid;
  end

  // Readys are gated by rst because the FSM sits in IDLE during reset.
  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign busy       = (state != IDLE);

  // Shift-and-add array on the latched operands.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 6; i++) begin
      if (g_q[i]) prod = prod + ({6'd0, f_q} << i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      f_q       <= '0;
      g_q       <= '0;
      id_q      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f_q   <= grant_id ? req1_f : req0_f;
            g_q   <= grant_id ? req1_g : req0_g;
            id_q  <= grant_id;
            ptr   <= ~grant_id;
            cnt   <= CNT_LOAD;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == 4'd0) begin
            res_data  <= prod;
            res_id    <= id_q;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (done_cnt != 8'hFF) done_cnt <= done_cnt + 8'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed stimulus pushes expected
// {id, product} entries; a negedge monitor pops them on result handshakes
// and checks accept-to-valid latency. Two extra instances cover
// CALC_CYCLES = 1 and 15.
module tb_mul_arbiter;

  localparam int MAIN_CC = 2;

  logic        clk;
  logic        rst;
  logic        r0v, r1v;
  logic [5:0]  r0f, r0g, r1f, r1g;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic        res_ready;
  logic [11:0] res_data;
  logic        res_id;
  logic        busy;
  logic [7:0]  done_cnt;

  logic        sw_v    [2];
  logic [5:0]  sw_f    [2];
  logic [5:0]  sw_g    [2];
  logic        sw_rdy  [2];
  logic        sw_rdy1 [2];
  logic        sw_rv   [2];
  logic [11:0] sw_data [2];
  logic        sw_id   [2];
  logic        sw_busy [2];
  logic [7:0]  sw_dc   [2];
  logic        sw_rr;
  logic        zero_b;
  logic [5:0]  zero6;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        rv_prev = 1'b0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  mul_arbiter #(.CALC_CYCLES(MAIN_CC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req1_valid(r1v),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_f(r0f), .req0_g(r0g), .req1_f(r1f), .req1_g(r1g),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id),
    .busy(busy), .done_cnt(done_cnt)
  );

  mul_arbiter #(.CALC_CYCLES(1)) dut_c1 (
    .clk(clk), .rst(rst),
    .req0_valid(sw_v[0]), .req1_valid(zero_b),
    .req0_ready(sw_rdy[0]), .req1_ready(sw_rdy1[0]),
    .req0_f(sw_f[0]), .req0_g(sw_g[0]), .req1_f(zero6), .req1_g(zero6),
    .res_valid(sw_rv[0]), .res_ready(sw_rr),
    .res_data(sw_data[0]), .res_id(sw_id[0]),
    .busy(sw_busy[0]), .done_cnt(sw_dc[0])
  );

  mul_arbiter #(.CALC_CYCLES(15)) dut_c15 (
    .clk(clk), .rst(rst),
    .req0_valid(sw_v[1]), .req1_valid(zero_b),
    .req0_ready(sw_rdy[1]), .req1_ready(sw_rdy1[1]),
    .req0_f(sw_f[1]), .req0_g(sw_g[1]), .req1_f(zero6), .req1_g(zero6),
    .res_valid(sw_rv[1]), .res_ready(sw_rr),
    .res_data(sw_data[1]), .res_id(sw_id[1]),
    .busy(sw_busy[1]), .done_cnt(sw_dc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: accepts and result handshakes are both visible at the negedge
  // before the edge that performs them.
  always @(negedge clk) begin
    if (!rst) begin
      if ((req0_ready && r0v) || (req1_ready && r1v)) acc_cyc = cyc + 1;
      if (res_valid && !rv_prev) chk("latency", cyc - acc_cyc, MAIN_CC);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_data", int'(res_data), int'(mon_e[11:0]));
          chk("res_id", int'(res_id), int'(mon_e[12]));
        end
      end
    end
    rv_prev = res_valid;
  end

  task automatic issue(input logic v0, input logic v1,
                       input logic [5:0] f0, input logic [5:0] g0,
                       input logic [5:0] f1, input logic [5:0] g1,
                       input int exp_data, input int exp_id,
                       input bit push, output int waited);
    int n;
    n = 0;
    r0v = v0; r1v = v1;
    r0f = f0; r0g = g0; r1f = f1; r1g = g1;
    do begin
      @(negedge clk);
      n++;
    end while (!((req0_ready && r0v) || (req1_ready && r1v)) && n < 200);
    waited = n;
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
    end else begin
      chk("grant_id", req1_ready ? 1 : 0, exp_id);
      if (push) exp_q.push_back({1'(exp_id), 12'(exp_data)});
    end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", int'(n < 200), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sweep(input int s, input int cc);
    logic [5:0] f, g;
    int n, lat;
    for (int t = 0; t < 6; t++) begin
      f = 6'($urandom_range(0, 63));
      g = 6'($urandom_range(0, 63));
      sw_f[s] = f; sw_g[s] = g; sw_v[s] = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!sw_rdy[s] && n < 50);
      chk($sformatf("sweep%0d_accept", cc), int'(sw_rdy[s]), 1);
      @(posedge clk); #1;
      sw_v[s] = 1'b0;
      lat = 0;
      while (!sw_rv[s] && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("sweep%0d_latency", cc), lat, cc);
      chk($sformatf("sweep%0d_data", cc), int'(sw_data[s]), int'(f) * int'(g));
      chk($sformatf("sweep%0d_id", cc), int'(sw_id[s]), 0);
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_released", cc), int'(sw_rv[s]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, dc;
    logic [5:0] f, g;
    rst = 1'b1;
    r0v = 0; r1v = 0; r0f = 0; r0g = 0; r1f = 0; r1g = 0;
    res_ready = 1'b1;
    sw_v[0] = 0; sw_v[1] = 0; sw_f[0] = 0; sw_f[1] = 0; sw_g[0] = 0; sw_g[1] = 0;
    sw_rr = 1'b1; zero_b = 1'b0; zero6 = '0;

    // Reset state, readys held low while rst=1 even with both valids up
    @(posedge clk); #1;
    r0v = 1; r1v = 1;
    @(negedge clk);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_cnt", int'(done_cnt), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_id", int'(res_id), 0);
    @(posedge clk); #1;
    r0v = 0; r1v = 0; rst = 1'b0;

    // Single requester, max operands, accepted on first edge after reset
    issue(1, 0, 63, 63, 0, 0, 'hF81, 0, 1, w);
    chk("first_accept_wait", w, 1);
    wait_idle();
    chk("single_done_cnt", int'(done_cnt), 1);
    chk("single_res_held", int'(res_data), 'hF81);
    chk("single_valid_low", int'(res_valid), 0);

    // Contention round robin from reset pointer
    do_reset();
    issue(1, 1, 5, 7, 9, 3, 35, 0, 1, w);
    issue(1, 1, 5, 7, 9, 3, 27, 1, 1, w);
    issue(1, 1, 5, 7, 9, 3, 35, 0, 1, w);
    wait_idle();
    chk("contention_done_cnt", int'(done_cnt), 3);

    // Backpressure with requests and operand churn during HOLD
    res_ready = 1'b0;
    issue(1, 0, 12, 11, 0, 0, 132, 0, 1, w);
    w = 0;
    while (!res_valid && w < 40) begin @(posedge clk); #1; w++; end
    chk("bp_valid_rose", int'(res_valid), 1);
    r0v = 1; r1v = 1; r0f = 1; r0g = 2; r1f = 3; r1g = 4;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_data", int'(res_data), 132);
      chk("bp_ready0", int'(req0_ready), 0);
      chk("bp_ready1", int'(req1_ready), 0);
    end
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    dc = int'(done_cnt);
    res_ready = 1'b1;
    wait_idle();
    chk("bp_done_inc", int'(done_cnt), dc + 1);
    repeat (3) @(posedge clk);
    #1 chk("bp_single_hs", int'(done_cnt), dc + 1);

    // Reset one cycle into CALC discards the operation
    issue(1, 0, 7, 9, 0, 0, 63, 0, 0, w);
    @(posedge clk); #1;
    rst = 1'b1; r0v = 1;
    @(negedge clk);
    chk("midrst_ready0", int'(req0_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0; r0v = 0;
    chk("midrst_done_cnt", int'(done_cnt), 0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_result", int'(res_valid), 0);
    end
    @(posedge clk); #1;
    issue(1, 0, 0, 63, 0, 0, 0, 0, 1, w);
    wait_idle();
    chk("zero_done_cnt", int'(done_cnt), 1);
    chk("zero_product", int'(res_data), 0);

    // 260 back-to-back results saturate done_cnt
    for (int i = 0; i < 260; i++) begin
      f = 6'(i % 64);
      g = 6'((i * 7 + 3) % 64);
      issue(1, 0, f, g, 0, 0, int'(f) * int'(g), 0, 1, w);
    end
    wait_idle();
    chk("sat_done_cnt", int'(done_cnt), 255);

    // Parameter sweep instances
    sweep(0, 1);
    sweep(1, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
